simd_loop_driver: RTL

Parametrised SIMD instruction sequencer, successor to the fixed single-shot SimdDriver. It holds a small writable instruction program and, on each launch, replays it a programmable number of times. Instructions go out one per cycle over the standard rdy/ack handshake to the SIMD datapath. Each issued instruction carries its program counter, repetition index and an end-of-launch flag.

---
 rtl/simd_loop_driver.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/simd_loop_driver.sv
// simd_loop_driver: replays a small writable instruction program a programmable
// number of times, issuing one instruction per cycle over an inst_rdy/inst_ack
// handshake. Each issued word carries its program index, pass index and an
// end-of-launch flag.
module simd_loop_driver #(
    parameter int IBW   = 32,
    parameter int DEPTH = 16,
    parameter int REPBW = 12,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wr,
    input  logic [AW-1:0]    i_waddr,
    input  logic [IBW-1:0]   i_wdata,
    input  logic             launch_rdy,
    output logic             launch_ack,
    input  logic [LW-1:0]    i_len,
    input  logic [REPBW-1:0] i_rep,
    output logic             inst_rdy,
    input  logic             inst_ack,
    output logic [IBW-1:0]   o_inst,
    output logic [AW-1:0]    o_pc,
    output logic [REPBW-1:0] o_rep,
    output logic             o_last,
    output logic             o_busy
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [LW-1:0]      len_q, len_d;
    logic [REPBW-1:0]   rep_lim_q, rep_lim_d;
    logic [AW-1:0]      pc_q, pc_d;
    logic [REPBW-1:0]   rep_q, rep_d;
    logic               rdy_q, rdy_d;
    logic               last_q, last_d;
    logic [IBW-1:0]     inst_q;
    logic               load_inst;
    logic               wr_en;

    logic [IBW-1:0]     mem [DEPTH];

    logic [LW-1:0]      len_m1;
    logic               pc_at_end;
    logic               rep_at_end;

    // Launch handshake: only accepted from IDLE and never while reset is held.
    assign launch_ack = launch_rdy && (state_q == ST_IDLE) && i_rst;

    // The program may only change while nothing is running or being launched,
    // so the memory is stable for the whole of a run.
    assign wr_en = i_wr && (state_q == ST_IDLE) && !launch_ack;

    assign len_m1     = len_q - LW'(1);
    assign pc_at_end  = ({1'b0, pc_q} == len_m1);
    assign rep_at_end = (rep_q == rep_lim_q);

    // Next-state logic: launch, in-pass step, pass wrap and end of launch.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        rep_lim_d = rep_lim_q;
        pc_d      = pc_q;
        rep_d     = rep_q;
        rdy_d     = rdy_q;
        last_d    = last_q;
        load_inst = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (launch_ack && (i_len != '0)) begin
                    state_d   = ST_RUN;
                    len_d     = i_len;
                    rep_lim_d = i_rep;
                    pc_d      = '0;
                    rep_d     = '0;
                    rdy_d     = 1'b1;
                    last_d    = (i_len == LW'(1)) && (i_rep == '0);
                    load_inst = 1'b1;
                end
            end
            ST_RUN: begin
                if (inst_ack) begin
                    if (!pc_at_end) begin
                        pc_d      = pc_q + AW'(1);
                        last_d    = ({1'b0, pc_d} == len_m1) && rep_at_end;
                        load_inst = 1'b1;
                    end else if (!rep_at_end) begin
                        pc_d      = '0;
                        rep_d     = rep_q + REPBW'(1);
                        last_d    = (len_q == LW'(1)) && (rep_d == rep_lim_q);
                        load_inst = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        rdy_d   = 1'b0;
                        last_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                rdy_d   = 1'b0;
                last_d  = 1'b0;
            end
        endcase
    end

    // Control and output registers; the instruction word is read from the
    // program memory at the same edge that advances the program counter.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q   <= ST_IDLE;
            len_q     <= '0;
            rep_lim_q <= '0;
            pc_q      <= '0;
            rep_q     <= '0;
            rdy_q     <= 1'b0;
            last_q    <= 1'b0;
            inst_q    <= '0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            rep_lim_q <= rep_lim_d;
            pc_q      <= pc_d;
            rep_q     <= rep_d;
            rdy_q     <= rdy_d;
            last_q    <= last_d;
            if (load_inst) begin
                inst_q <= mem[pc_d];
            end
        end
    end

    // Program memory write port; contents survive reset.
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem[i_waddr] <= i_wdata;
        end
    end

    assign inst_rdy = rdy_q;
    assign o_inst   = inst_q;
    assign o_pc     = pc_q;
    assign o_rep    = rep_q;
    assign o_last   = last_q;
    assign o_busy   = (state_q == ST_RUN);

endmodule
